usb_output: RTL and testbench

//  Transmit-side counterpart of usb_input. Buffers bytes from the audio/flash logic
//  and writes them to the FTDI FT245 USB FIFO through its 8-bit parallel write port (TXE#, WR).

---
 rtl/usb_output.sv | 184 ++++++++++++++++++
 tb/tb_usb_output.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_output.sv
`default_nettype none
// ============================================================================
// Module   : usb_output
// Purpose  : Byte FIFO feeding the FT245 parallel write port (TXE#, WR),
//            with setup / strobe / recovery timing around each write.
// Option   : USB_TX_COUNT_EN adds the 16-bit bytes_sent counter port.
// Revision : 1.0  initial release
// ============================================================================
module usb_output #(
  parameter int DEPTH_LOG2     = 4,
  parameter int SETUP_CYCLES   = 1,
  parameter int WR_CYCLES      = 2,
  parameter int RECOVER_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       newin,
  output logic       full,
  output logic       overflow,
  output logic       idle,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic       txe,
  output logic       wr
`ifdef USB_TX_COUNT_EN
  ,
  output logic [15:0] bytes_sent
`endif
);

  localparam int                  DEPTH        = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_FULL   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [7:0]          SETUP_LOAD   = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0]          WR_LOAD      = 8'(WR_CYCLES - 1);
  localparam logic [7:0]          RECOVER_LOAD = 8'(RECOVER_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_STROBE  = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  // TXE# comes straight from the FT245 pin, so it is double-registered
  logic txe_meta;
  logic txe_s;

  always_ff @(posedge clock) begin
    txe_meta <= txe;
    txe_s    <= txe_meta;
  end

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  push;
  logic                  pop;

  assign full = (count == COUNT_FULL);
  assign push = newin & ~full;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (newin && full) begin
        overflow <= 1'b1;
      end
    end
  end

  state_t     state;
  state_t     state_nxt;
  logic [7:0] timer;
  logic [7:0] timer_nxt;
  logic       wr_nxt;
  logic       oe_nxt;
  logic [7:0] dout_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      timer    <= '0;
      wr       <= 1'b0;
      data_oe  <= 1'b0;
      data_out <= '0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      wr       <= wr_nxt;
      data_oe  <= oe_nxt;
      data_out <= dout_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    wr_nxt    = wr;
    oe_nxt    = data_oe;
    dout_nxt  = data_out;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        wr_nxt = 1'b0;
        oe_nxt = 1'b0;
        if ((count != '0) && !txe_s) begin
          dout_nxt  = mem[rd_ptr];
          oe_nxt    = 1'b1;
          timer_nxt = SETUP_LOAD;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (timer == 8'd0) begin
          wr_nxt    = 1'b1;
          timer_nxt = WR_LOAD;
          state_nxt = S_STROBE;
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end
      S_STROBE: begin
        // TXE# is not consulted here: once WR is up the write always completes
        if (timer == 8'd0) begin
          wr_nxt    = 1'b0;
          pop       = 1'b1;
          timer_nxt = RECOVER_LOAD;
          state_nxt = S_RECOVER;
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end
      S_RECOVER: begin
        // data_oe was still 1 on entry, giving one cycle of hold after WR falls
        oe_nxt = 1'b0;
        if (timer == 8'd0) begin
          state_nxt = S_IDLE;
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign idle = (count == '0) && (state == S_IDLE);

`ifdef USB_TX_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      bytes_sent <= '0;
    end else if (pop) begin
      bytes_sent <= bytes_sent + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_output.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_output
// Purpose  : Directed self-checking bench for usb_output (default parameters).
// Revision : 1.0  initial release
// ============================================================================
module tb_usb_output;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in    = 8'h00;
  logic       newin = 1'b0;
  logic       txe   = 1'b0;
  logic       full;
  logic       overflow;
  logic       idle;
  logic [7:0] data_out;
  logic       data_oe;
  logic       wr;
`ifdef USB_TX_COUNT_EN
  logic [15:0] bytes_sent;
`endif

  always #5 clock = ~clock;

  usb_output dut (
    .clock    (clock),
    .reset    (reset),
    .in       (in),
    .newin    (newin),
    .full     (full),
    .overflow (overflow),
    .idle     (idle),
    .data_out (data_out),
    .data_oe  (data_oe),
    .txe      (txe),
    .wr       (wr)
`ifdef USB_TX_COUNT_EN
    ,
    .bytes_sent (bytes_sent)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Bytes as the FT245 would latch them: on the WR falling edge while driven
  logic [7:0] got [$];
  logic       prev_wr = 1'b0;

  always @(negedge clock) begin
    if (prev_wr && !wr && data_oe) got.push_back(data_out);
    prev_wr = wr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    in    = b;
    newin = 1'b1;
    tick();
    newin = 1'b0;
  endtask

  task automatic wait_pulses(input string tag, input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, got.size(), n);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (!idle && k < budget) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, idle}, 32'd1);
  endtask

  task automatic wait_wr_high(input string tag, input int budget);
    int k = 0;
    while (!wr && k < budget) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, wr}, 32'd1);
  endtask

  function automatic logic [7:0] got_at(input int i);
    logic [7:0] v = 8'hxx;
    if (i < got.size()) v = got[i];
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    reset = 1'b1;
    txe   = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_wr",       {31'd0, wr},       32'd0);
    chk("rst_data_oe",  {31'd0, data_oe},  32'd0);
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_full",     {31'd0, full},     32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_idle",     {31'd0, idle},     32'd1);

    // Single byte: exact cycle-by-cycle timing relative to the push edge E
    push(8'hA5);
    chk("t1_idle_e0", {31'd0, idle},    32'd0);
    chk("t1_oe_e0",   {31'd0, data_oe}, 32'd0);
    tick();
    chk("t1_oe_e1",   {31'd0, data_oe}, 32'd1);
    chk("t1_wr_e1",   {31'd0, wr},      32'd0);
    tick();
    chk("t1_wr_e2",   {31'd0, wr},      32'd1);
    tick();
    chk("t1_wr_e3",   {31'd0, wr},      32'd1);
    tick();
    chk("t1_wr_e4",   {31'd0, wr},      32'd0);
    chk("t1_dout_e4", {24'd0, data_out}, 32'hA5);
    chk("t1_oe_e4",   {31'd0, data_oe}, 32'd1);
    tick();
    chk("t1_oe_e5",   {31'd0, data_oe}, 32'd0);
    repeat (2) tick();
    chk("t1_idle_e7", {31'd0, idle},    32'd0);
    tick();
    chk("t1_idle_e8", {31'd0, idle},    32'd1);
    chk("t1_count",   got.size(), 1);
    chk("t1_byte",    {24'd0, got_at(0)}, 32'hA5);
    got.delete();

    // Fill to full with TXE# high, overflow on the 17th, then drain in order
    txe = 1'b1;
    repeat (3) tick();
    for (int i = 1; i <= 16; i++) push(8'(i));
    chk("t2_full",        {31'd0, full},     32'd1);
    chk("t2_ovf_before",  {31'd0, overflow}, 32'd0);
    push(8'h11);
    chk("t2_full_after",  {31'd0, full},     32'd1);
    chk("t2_ovf_after",   {31'd0, overflow}, 32'd1);
    repeat (5) tick();
    chk("t2_no_wr",       got.size(), 0);
    txe = 1'b0;
    wait_pulses("t2_pulses", 16, 200);
    for (int i = 0; i < 16; i++)
      chk($sformatf("t2_byte%0d", i), {24'd0, got_at(i)}, 32'(i + 1));
    wait_idle("t2_idle", 40);
    repeat (10) tick();
    chk("t2_no_extra",    got.size(), 16);
    chk("t2_full_drain",  {31'd0, full},     32'd0);
    chk("t2_ovf_sticky",  {31'd0, overflow}, 32'd1);
    got.delete();

    // TXE# high blocks writes; latency from TXE# fall to WR rise is 4 clocks
    txe = 1'b1;
    repeat (3) tick();
    push(8'h21);
    push(8'h22);
    push(8'h23);
    repeat (20) tick();
    chk("t3_blocked", got.size(), 0);
    chk("t3_wr_low",  {31'd0, wr}, 32'd0);
    txe = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      tick();
      if (wr) lat = k;
    end
    chk("t3_latency", lat, 4);
    wait_pulses("t3_pulses", 3, 60);
    chk("t3_byte0", {24'd0, got_at(0)}, 32'h21);
    chk("t3_byte1", {24'd0, got_at(1)}, 32'h22);
    chk("t3_byte2", {24'd0, got_at(2)}, 32'h23);
    wait_idle("t3_idle", 40);
    got.delete();

    // TXE# rises mid-strobe: current write completes, next one waits
    push(8'h3C);
    push(8'h3D);
    wait_wr_high("t4_wr_rise", 10);
    txe = 1'b1;
    repeat (25) tick();
    chk("t4_one_pulse", got.size(), 1);
    chk("t4_byte0",     {24'd0, got_at(0)}, 32'h3C);
    chk("t4_pending",   {31'd0, idle},      32'd0);
    chk("t4_oe_off",    {31'd0, data_oe},   32'd0);
    txe = 1'b0;
    wait_pulses("t4_pulses", 2, 30);
    chk("t4_byte1",     {24'd0, got_at(1)}, 32'h3D);
    wait_idle("t4_idle", 40);
    got.delete();

    // Reset during an active strobe aborts the write and empties the FIFO
    push(8'h55);
    push(8'h66);
    push(8'h77);
    wait_wr_high("t5_wr_rise", 10);
    reset = 1'b1;
    tick();
    chk("t5_wr",       {31'd0, wr},       32'd0);
    chk("t5_oe",       {31'd0, data_oe},  32'd0);
    chk("t5_idle",     {31'd0, idle},     32'd1);
    chk("t5_overflow", {31'd0, overflow}, 32'd0);
    chk("t5_full",     {31'd0, full},     32'd0);
    reset = 1'b0;
    repeat (30) tick();
    chk("t5_no_pulse", got.size(), 0);
    chk("t5_wr_quiet", {31'd0, wr}, 32'd0);

`ifdef USB_TX_COUNT_EN
    chk("t6_cnt_rst", {16'd0, bytes_sent}, 32'd0);
    push(8'h01);
    push(8'h02);
    wait_pulses("t6_pulses", 2, 40);
    wait_idle("t6_idle", 40);
    chk("t6_cnt", {16'd0, bytes_sent}, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
